// File: rtl/data_memory_mmio_pkg.sv
// Memory map shared by the data memory top level and its bench: I/O window
// bases and widths, region encoding, and the address decode helpers.
package mem_map_pkg;

  localparam int unsigned GPIO_OUT_BASE = 0;
  localparam int unsigned GPIO_IN_BASE  = 36;
  localparam int unsigned SW_BASE       = 72;
  localparam int unsigned RAM_BASE      = 76;
  localparam int unsigned GPIO_W        = 36;
  localparam int unsigned SW_W          = 4;
  localparam int unsigned IO_IDX_W      = 6;
  localparam int unsigned SW_IDX_W      = 2;
  localparam int unsigned QB_W          = 8;

  typedef enum logic [1:0] {R_GPIO_OUT, R_GPIO_IN, R_SW, R_RAM} region_t;

  function automatic region_t decode_region(input logic [31:0] addr);
    if (addr < 32'(GPIO_IN_BASE)) return R_GPIO_OUT;
    if (addr < 32'(SW_BASE))      return R_GPIO_IN;
    if (addr < 32'(RAM_BASE))     return R_SW;
    return R_RAM;
  endfunction

  // Bit index inside the selected I/O window; meaningless for R_RAM.
  function automatic logic [IO_IDX_W-1:0] io_index(input logic [31:0] addr, input region_t r);
    case (r)
      R_GPIO_IN: return IO_IDX_W'(addr - 32'(GPIO_IN_BASE));
      R_SW:      return IO_IDX_W'(addr - 32'(SW_BASE));
      default:   return IO_IDX_W'(addr - 32'(GPIO_OUT_BASE));
    endcase
  endfunction

endpackage

// File: rtl/data_memory_mmio_if.sv
// CPU load/store port (A) and read-only byte port (B) of the data memory.
interface data_memory_mmio_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 24
);
  logic              memWrite;
  logic [ADDR_W-1:0] address1;
  logic [DATA_W-1:0] data1;
  logic [ADDR_W-1:0] address2;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] qa;
  logic [7:0]        qb;

  modport master (
    output memWrite, address1, data1, address2, data2,
    input  qa, qb
  );

  modport slave (
    input  memWrite, address1, data1, address2, data2,
    output qa, qb
  );
endinterface

// File: rtl/data_memory_mmio_dp_ram.sv
// Simple dual-port RAM: port A read/write (write-first), port B read-only low
// byte with bypass of a same-edge port A write. Array has no reset.
module dp_ram #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 2**19,
  parameter int unsigned QB_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [QB_W-1:0]   q_b
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_a_d, q_a_q;
  logic [QB_W-1:0]   q_b_d, q_b_q;

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  always_comb begin
    q_a_d = mem[addr_a];
    q_b_d = mem[addr_b][QB_W-1:0];
    if (we_a) begin
      q_a_d = din_a;
      if (addr_a == addr_b) q_b_d = din_a[QB_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory with a memory-mapped GPIO/switch window on port A; port B reads
// the raw RAM low byte with no I/O decode.
module data_memory_mmio
  import mem_map_pkg::*;
#(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 2**19
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_mmio_if.slave bus,
  input  logic [SW_W-1:0]   switches,
  input  logic [GPIO_W-1:0] gpio1,
  output logic [GPIO_W-1:0] gpio2
);

  region_t             region_a, region_d, region_q;
  logic [IO_IDX_W-1:0] idx;
  logic                io_we, ram_we;
  logic [GPIO_W-1:0]   gpio2_d, gpio2_q;
  logic                io_bit_d, io_bit_q;
  logic [DATA_W-1:0]   ram_qa;
  logic                unused_data2;

  // Decode, GPIO-out update and write-first I/O read bit.
  always_comb begin
    region_a     = decode_region(32'(bus.address1));
    idx          = io_index(32'(bus.address1), region_a);
    io_we        = bus.memWrite && !rst && (region_a == R_GPIO_OUT);
    ram_we       = bus.memWrite && !rst && (region_a == R_RAM);
    region_d     = region_a;
    gpio2_d      = gpio2_q;
    io_bit_d     = 1'b0;
    unused_data2 = ^bus.data2;
    if (io_we) gpio2_d[idx] = bus.data1[0];
    case (region_a)
      R_GPIO_OUT: io_bit_d = gpio2_d[idx];
      R_GPIO_IN:  io_bit_d = gpio1[idx];
      R_SW:       io_bit_d = switches[SW_IDX_W'(idx)];
      default:    io_bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio2_q  <= '0;
      region_q <= R_GPIO_OUT;
      io_bit_q <= 1'b0;
    end else begin
      gpio2_q  <= gpio2_d;
      region_q <= region_d;
      io_bit_q <= io_bit_d;
    end
  end

  dp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .QB_W   (QB_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_a   (ram_we),
    .addr_a (bus.address1),
    .din_a  (bus.data1),
    .q_a    (ram_qa),
    .addr_b (bus.address2),
    .q_b    (bus.qb)
  );

  assign bus.qa = (region_q == R_RAM) ? ram_qa : DATA_W'(io_bit_q);
  assign gpio2  = gpio2_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: stimulus pushes expected values into a
// scoreboard queue, an independent monitor pops and compares them.
module tb_data_memory_mmio;

  localparam int K_QA    = 0;
  localparam int K_QB    = 1;
  localparam int K_GPIO2 = 2;

  typedef struct {
    int          cyc;
    int          kind;
    string       name;
    logic [35:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  switches = '0;
  logic [35:0] gpio1 = '0;
  logic [35:0] gpio2;

  data_memory_mmio_if bus ();

  data_memory_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .switches (switches),
    .gpio1    (gpio1),
    .gpio2    (gpio2)
  );

  always #5 clk = ~clk;

  sb_entry_t sb[$];
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  event      chk_ev;

  task automatic push(input int when, input int kind, input string name, input logic [35:0] v);
    sb_entry_t e;
    e.cyc = when; e.kind = kind; e.name = name; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_next(input int kind, input string name, input logic [35:0] v);
    push(cyc + 1, kind, name, v);
  endtask

  task automatic exp_now_reset(input string tag);
    #1;
    push(cyc, K_QA, {tag, "_qa"}, 36'd0);
    push(cyc, K_QB, {tag, "_qb"}, 36'd0);
    push(cyc, K_GPIO2, {tag, "_gpio2"}, 36'd0);
    -> chk_ev;
  endtask

  task automatic drive(input logic we, input int a1, input logic [23:0] d1, input int a2);
    bus.memWrite = we;
    bus.address1 = 19'(a1);
    bus.data1    = d1;
    bus.address2 = 19'(a2);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: drain every entry that has come due, after each edge or on demand.
  initial begin
    sb_entry_t   e;
    logic [35:0] act;
    forever begin
      @(posedge clk or chk_ev);
      if (clk) begin
        #2;
        cyc++;
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.kind)
          K_QA:    act = 36'(bus.qa);
          K_QB:    act = 36'(bus.qb);
          default: act = gpio2;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 75, 24'd0, 0);
    bus.data2 = 24'hFFFFFF;
    switches  = 4'b1010;
    #1 rst = 1'b1;

    // Reset and switch window
    tick();
    exp_now_reset("rst_init");
    exp_next(K_QA, "qa_in_reset", 36'd0);
    tick();
    rst = 1'b0;
    exp_next(K_QA, "sw3", 36'd1);
    tick();
    drive(1'b0, 72, 24'd0, 0);
    exp_next(K_QA, "sw0", 36'd0);
    tick();

    // RAM write-first then hold
    drive(1'b1, 5000, 24'd255, 0);
    exp_next(K_QA, "ram_wr_first", 36'd255);
    tick();
    drive(1'b0, 5000, 24'd27, 0);
    exp_next(K_QA, "ram_no_write", 36'd255);
    tick();
    drive(1'b1, 76, 24'h123456, 0);
    exp_next(K_QA, "ram_base_wr", 36'h123456);
    tick();

    // GPIO out
    drive(1'b1, 30, 24'd1, 0);
    exp_next(K_GPIO2, "gpio2_set30", 36'h0_4000_0000);
    exp_next(K_QA, "gpo30_wr_first", 36'd1);
    tick();
    drive(1'b0, 30, 24'd0, 0);
    exp_next(K_QA, "gpo30_read", 36'd1);
    tick();
    drive(1'b1, 30, 24'd0, 0);
    exp_next(K_GPIO2, "gpio2_clr30", 36'd0);
    exp_next(K_QA, "gpo30_clr_read", 36'd0);
    tick();
    drive(1'b1, 35, 24'hFFFFFF, 0);
    exp_next(K_GPIO2, "gpio2_set35", 36'h8_0000_0000);
    tick();

    // GPIO in, including a write that must be ignored
    gpio1 = 36'd4;
    drive(1'b0, 38, 24'd0, 0);
    exp_next(K_QA, "gpi2", 36'd1);
    tick();
    drive(1'b0, 37, 24'd0, 0);
    exp_next(K_QA, "gpi1", 36'd0);
    tick();
    drive(1'b1, 38, 24'd0, 0);
    exp_next(K_QA, "gpi2_after_wr", 36'd1);
    exp_next(K_GPIO2, "gpio2_untouched", 36'h8_0000_0000);
    tick();
    gpio1 = 36'h8_0000_0000;
    drive(1'b0, 71, 24'd0, 0);
    exp_next(K_QA, "gpi35", 36'd1);
    tick();

    // Port B
    drive(1'b1, 100, 24'hABCD02, 0);
    exp_next(K_QA, "ram100_wr", 36'hABCD02);
    tick();
    drive(1'b0, 0, 24'd0, 100);
    exp_next(K_QB, "qb100", 36'h02);
    tick();
    drive(1'b0, 0, 24'd0, 76);
    exp_next(K_QB, "qb76", 36'h56);
    tick();
    drive(1'b1, 200, 24'h5A5A77, 200);
    exp_next(K_QB, "qb200_bypass", 36'h77);
    exp_next(K_QA, "qa200_wr", 36'h5A5A77);
    tick();
    drive(1'b0, 200, 24'd0, 200);
    exp_next(K_QB, "qb200_hold", 36'h77);
    tick();

    // Async reset mid-cycle, aborting a pending write
    drive(1'b1, 5, 24'd1, 100);
    exp_next(K_GPIO2, "gpio2_set5", 36'h8_0000_0020);
    exp_next(K_QA, "gpo5_wr", 36'd1);
    exp_next(K_QB, "qb100_pre_rst", 36'h02);
    tick();
    drive(1'b1, 100, 24'hFFFFFF, 100);
    #2 rst = 1'b1;
    exp_now_reset("rst_async");
    exp_next(K_QA, "qa_rst_edge", 36'd0);
    exp_next(K_QB, "qb_rst_edge", 36'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 100, 24'd0, 100);
    exp_next(K_QA, "ram100_kept", 36'hABCD02);
    exp_next(K_QB, "qb100_kept", 36'h02);
    exp_next(K_GPIO2, "gpio2_post_rst", 36'd0);
    tick();

    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
